// File: rtl/jtag_host_driver.sv
// JTAG initiator: runs TAP-reset, IR-scan, DR-scan and idle-clock commands on a divided TCK
// and returns the captured TDO bits with a one-cycle response strobe.
module jtag_host_driver #(
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 5,
    parameter int HALF_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmdValid,
    output logic              o_cmdReady,
    input  logic [1:0]        i_cmdOp,
    input  logic [LEN_W-1:0]  i_cmdLen,
    input  logic [DATA_W-1:0] i_cmdData,
    output logic              o_rspValid,
    output logic [DATA_W-1:0] o_rspData,
    output logic              o_busy,
    output logic              o_jtagTCK,
    output logic              o_jtagTMS,
    output logic              o_jtagTDI,
    input  logic              i_jtagTDO
);

    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int IDX_W = $clog2(DATA_W);

    // Handshake: a command transfers on a rising i_clk edge where i_cmdValid and o_cmdReady
    // are both high; o_rspValid is a single-cycle strobe and o_cmdReady is high in that cycle.
    typedef enum logic [2:0] {
        S_AUTO_INIT,
        S_IDLE,
        S_PRE,
        S_SHIFT,
        S_POST,
        S_TRST,
        S_RUNIDLE,
        S_DONE
    } state_t;

    state_t              state_q, state_d, acc_state;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, acc_len;
    logic                is_ir_q, acc_ir;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   rsp_q;
    logic [DIV_W-1:0]    div_q;
    logic                tck_q, tms_q, tdi_q;
    logic                tms_d, tdi_d, acc_tms;
    logic                ready_q, busy_q, rsp_valid_q;
    logic                tdo_meta_q, tdo_sync_q;
    logic                half_end, rise_evt, fall_evt;

    // Index of the final TCK within the current segment.
    function automatic logic [LEN_W-1:0] seg_last(state_t st, logic ir, logic [LEN_W-1:0] len);
        case (st)
            S_AUTO_INIT, S_TRST: seg_last = LEN_W'(5);
            S_PRE:               seg_last = ir ? LEN_W'(3) : LEN_W'(2);
            S_SHIFT, S_RUNIDLE:  seg_last = len - LEN_W'(1);
            S_POST:              seg_last = LEN_W'(1);
            default:             seg_last = '0;
        endcase
    endfunction

    function automatic logic tms_at(state_t st, logic [LEN_W-1:0] cnt, logic ir,
                                    logic [LEN_W-1:0] len);
        case (st)
            S_AUTO_INIT, S_TRST: tms_at = (cnt != LEN_W'(5));
            S_PRE:               tms_at = ir ? (cnt < LEN_W'(2)) : (cnt == '0);
            S_SHIFT:             tms_at = (cnt == len - LEN_W'(1));
            S_POST:              tms_at = (cnt == '0);
            default:             tms_at = 1'b0;
        endcase
    endfunction

    assign half_end = (div_q == DIV_W'(HALF_DIV - 1));
    assign rise_evt = half_end & ~tck_q;
    assign fall_evt = half_end & tck_q;

    always_comb begin
        acc_ir    = (i_cmdOp == 2'b01);
        acc_len   = i_cmdLen;
        acc_state = S_RUNIDLE;
        case (i_cmdOp)
            2'b00: acc_state = S_TRST;
            2'b01, 2'b10: begin
                acc_state = S_PRE;
                if (i_cmdLen == '0) begin
                    acc_len = LEN_W'(1);
                end else if (i_cmdLen > LEN_W'(DATA_W)) begin
                    acc_len = LEN_W'(DATA_W);
                end
            end
            default: acc_state = S_RUNIDLE;
        endcase
        acc_tms = tms_at(acc_state, '0, acc_ir, acc_len);
    end

    // Position of the next TCK once the current one completes on the falling edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + LEN_W'(1);
        if (cnt_q == seg_last(state_q, is_ir_q, len_q)) begin
            cnt_d = '0;
            case (state_q)
                S_AUTO_INIT: state_d = S_IDLE;
                S_PRE:       state_d = S_SHIFT;
                S_SHIFT:     state_d = S_POST;
                default:     state_d = S_DONE;
            endcase
        end
        tms_d = tms_at(state_d, cnt_d, is_ir_q, len_q);
        tdi_d = (state_d == S_SHIFT) ? data_q[cnt_d[IDX_W-1:0]] : 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tdo_meta_q <= 1'b0;
            tdo_sync_q <= 1'b0;
        end else begin
            tdo_meta_q <= i_jtagTDO;
            tdo_sync_q <= tdo_meta_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_AUTO_INIT;
            cnt_q       <= '0;
            len_q       <= '0;
            is_ir_q     <= 1'b0;
            data_q      <= '0;
            rsp_q       <= '0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (i_cmdValid && ready_q) begin
                        state_q <= acc_state;
                        len_q   <= acc_len;
                        is_ir_q <= acc_ir;
                        data_q  <= i_cmdData;
                        rsp_q   <= '0;
                        cnt_q   <= '0;
                        div_q   <= '0;
                        tms_q   <= acc_tms;
                        tdi_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    if (state_q == S_RUNIDLE && len_q == '0) begin
                        state_q     <= S_DONE;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        div_q <= half_end ? '0 : div_q + DIV_W'(1);
                        if (rise_evt) begin
                            tck_q <= 1'b1;
                            if (state_q == S_SHIFT) begin
                                rsp_q[cnt_q[IDX_W-1:0]] <= tdo_sync_q;
                            end
                        end
                        if (fall_evt) begin
                            tck_q   <= 1'b0;
                            state_q <= state_d;
                            cnt_q   <= cnt_d;
                            tms_q   <= tms_d;
                            tdi_q   <= tdi_d;
                            if (state_d == S_IDLE || state_d == S_DONE) begin
                                ready_q     <= 1'b1;
                                busy_q      <= 1'b0;
                                rsp_valid_q <= (state_d == S_DONE);
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign o_cmdReady = ready_q;
    assign o_rspValid = rsp_valid_q;
    assign o_rspData  = rsp_q;
    assign o_busy     = busy_q;
    assign o_jtagTCK  = tck_q;
    assign o_jtagTMS  = tms_q;
    assign o_jtagTDI  = tdi_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Directed bench for jtag_host_driver against a behavioural TAP controller model.
module tb_jtag_host_driver;
  localparam int DATA_W   = 16;
  localparam int LEN_W    = 5;
  localparam int HALF_DIV = 4;

  localparam int TLR = 0, RTI = 1, SEL_DR = 2, CAP_DR = 3, SH_DR = 4, EX1_DR = 5, PAU_DR = 6,
                 EX2_DR = 7, UPD_DR = 8, SEL_IR = 9, CAP_IR = 10, SH_IR = 11, EX1_IR = 12,
                 PAU_IR = 13, EX2_IR = 14, UPD_IR = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op    = 2'b00;
  logic [LEN_W-1:0]  cmd_len   = '0;
  logic [DATA_W-1:0] cmd_data  = '0;
  logic              cmd_ready, rsp_valid, busy, tck, tms, tdi;
  logic [DATA_W-1:0] rsp_data;
  logic              tdo = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  jtag_host_driver #(.DATA_W(DATA_W), .LEN_W(LEN_W), .HALF_DIV(HALF_DIV)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cmdValid (cmd_valid),
    .o_cmdReady (cmd_ready),
    .i_cmdOp    (cmd_op),
    .i_cmdLen   (cmd_len),
    .i_cmdData  (cmd_data),
    .o_rspValid (rsp_valid),
    .o_rspData  (rsp_data),
    .o_busy     (busy),
    .o_jtagTCK  (tck),
    .o_jtagTMS  (tms),
    .o_jtagTDI  (tdi),
    .i_jtagTDO  (tdo)
  );

  // cycle, handshake and strobe monitors
  int cyc = 0;
  int acc_cnt = 0;
  int rsp_pulses = 0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cmd_valid && cmd_ready) acc_cnt = acc_cnt + 1;
    if (rsp_valid) rsp_pulses = rsp_pulses + 1;
  end

  // TAP target model and TCK log
  int          tap_st = PAU_IR;
  logic [15:0] tap_dr = 16'h1234;
  logic [15:0] tap_dr_sr = 16'h0;
  logic [3:0]  tap_ir = 4'h1;
  logic [3:0]  tap_ir_sr = 4'h0;
  logic        tck_tms[$];
  logic        tck_tdi[$];
  int          rise_cyc[$];

  function automatic int tap_next(int st, logic m);
    case (st)
      TLR:     return m ? TLR : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PAU_DR;
      PAU_DR:  return m ? EX2_DR : PAU_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PAU_IR;
      PAU_IR:  return m ? EX2_IR : PAU_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      UPD_IR:  return m ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge tck) begin
    tck_tms.push_back(tms);
    tck_tdi.push_back(tdi);
    rise_cyc.push_back(cyc);
    case (tap_st)
      TLR:     tap_ir = 4'h1;
      CAP_DR:  tap_dr_sr = tap_dr;
      SH_DR:   tap_dr_sr = {tdi, tap_dr_sr[15:1]};
      UPD_DR:  tap_dr = tap_dr_sr;
      CAP_IR:  tap_ir_sr = 4'b0101;
      SH_IR:   tap_ir_sr = {tdi, tap_ir_sr[3:1]};
      UPD_IR:  tap_ir = tap_ir_sr;
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms);
  end

  always @(negedge tck) begin
    if (tap_st == SH_DR) tdo = tap_dr_sr[0];
    else if (tap_st == SH_IR) tdo = tap_ir_sr[0];
    else tdo = 1'b0;
  end

  // driver tasks
  task automatic grab(input int start, output int n, output logic [31:0] v_tms,
                      output logic [31:0] v_tdi);
    n = tck_tms.size() - start;
    v_tms = '0;
    v_tdi = '0;
    for (int i = 0; i < n && i < 32; i++) begin
      v_tms[i] = tck_tms[start + i];
      v_tdi[i] = tck_tdi[start + i];
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len,
                          input logic [DATA_W-1:0] data);
    int guard = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (guard >= 2000) begin
      n_err++;
      $display("FAIL cmd_ready_timeout: ready=%b after %0d cycles, required 1", cmd_ready, guard);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len,
                        input logic [DATA_W-1:0] data, output int n, output logic [31:0] v_tms,
                        output logic [31:0] v_tdi, output logic [DATA_W-1:0] rsp,
                        output bit got, output bit pulse_ok);
    int start;
    start = tck_tms.size();
    send_cmd(op, len, data);
    got = 1'b0;
    rsp = '0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        rsp = rsp_data;
      end else begin
        @(negedge clk);
      end
    end
    pulse_ok = got && (cmd_ready === 1'b1);
    @(negedge clk);
    pulse_ok = pulse_ok && (rsp_valid === 1'b0) && (rsp_data === rsp);
    grab(start, n, v_tms, v_tdi);
  endtask

  // tests
  task automatic test_reset();
    int start, n, guard, p0, period;
    logic [31:0] v_tms, v_tdi;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({tck, tms, tdi, cmd_ready, rsp_valid, busy} !== 6'b010001) begin
      n_err++;
      $display("FAIL reset_pins: tck,tms,tdi,rdy,rspv,busy=%b required 010001",
               {tck, tms, tdi, cmd_ready, rsp_valid, busy});
    end
    n_vec++;
    if (rsp_data !== 16'h0) begin
      n_err++;
      $display("FAIL reset_rspdata: got %h required 0000", rsp_data);
    end
    start = tck_tms.size();
    p0 = rsp_pulses;
    rst = 1'b0;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    grab(start, n, v_tms, v_tdi);
    period = (n >= 2) ? rise_cyc[start + 1] - rise_cyc[start] : -1;
    n_vec++;
    if (n != 6) begin n_err++; $display("FAIL init_tck_count: got %0d required 6", n); end
    n_vec++;
    if (v_tms[5:0] !== 6'b011111) begin
      n_err++;
      $display("FAIL init_tms: got %b required 011111", v_tms[5:0]);
    end
    n_vec++;
    if (period != 2 * HALF_DIV) begin
      n_err++;
      $display("FAIL tck_period: got %0d required %0d", period, 2 * HALF_DIV);
    end
    n_vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL init_ready_busy: ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
    n_vec++;
    if (rsp_pulses != p0) begin
      n_err++;
      $display("FAIL init_rspvalid: got %0d pulses required 0", rsp_pulses - p0);
    end
    n_vec++;
    if (tap_st != RTI) begin
      n_err++;
      $display("FAIL init_tap_state: got %0d required %0d", tap_st, RTI);
    end
  endtask

  task automatic test_dr_scan();
    int n;
    logic [31:0] v_tms, v_tdi;
    logic [DATA_W-1:0] rsp;
    bit got, pok;
    do_cmd(2'b10, 5'd16, 16'hA5C3, n, v_tms, v_tdi, rsp, got, pok);
    n_vec++;
    if (!got || !pok) begin
      n_err++;
      $display("FAIL dr16_rsp_pulse: got=%0d pulse_ok=%0d required 1 1", got, pok);
    end
    n_vec++;
    if (n != 21) begin n_err++; $display("FAIL dr16_tck_count: got %0d required 21", n); end
    n_vec++;
    if (v_tms[20:0] !== 21'h0C0001) begin
      n_err++;
      $display("FAIL dr16_tms: got %h required 0c0001", v_tms[20:0]);
    end
    n_vec++;
    if (v_tdi[18:3] !== 16'hA5C3) begin
      n_err++;
      $display("FAIL dr16_tdi: got %h required a5c3", v_tdi[18:3]);
    end
    n_vec++;
    if (rsp !== 16'h1234) begin
      n_err++;
      $display("FAIL dr16_rspdata: got %h required 1234", rsp);
    end
    n_vec++;
    if (tap_dr !== 16'hA5C3 || tap_st != RTI) begin
      n_err++;
      $display("FAIL dr16_tap: dr=%h st=%0d required a5c3 %0d", tap_dr, tap_st, RTI);
    end
  endtask

  task automatic test_ir_scan();
    int n;
    logic [31:0] v_tms, v_tdi;
    logic [DATA_W-1:0] rsp;
    bit got, pok;
    do_cmd(2'b01, 5'd4, 16'h0009, n, v_tms, v_tdi, rsp, got, pok);
    n_vec++;
    if (!got || !pok) begin
      n_err++;
      $display("FAIL ir4_rsp_pulse: got=%0d pulse_ok=%0d required 1 1", got, pok);
    end
    n_vec++;
    if (n != 10 || v_tms[9:0] !== 10'h183) begin
      n_err++;
      $display("FAIL ir4_tms: count %0d tms %b required 10 0110000011", n, v_tms[9:0]);
    end
    n_vec++;
    if (v_tdi[7:4] !== 4'h9) begin
      n_err++;
      $display("FAIL ir4_tdi: got %b required 1001", v_tdi[7:4]);
    end
    n_vec++;
    if (rsp !== 16'h0005) begin
      n_err++;
      $display("FAIL ir4_rspdata: got %h required 0005", rsp);
    end
    n_vec++;
    if (tap_ir !== 4'h9 || tap_st != RTI) begin
      n_err++;
      $display("FAIL ir4_tap: ir=%h st=%0d required 9 %0d", tap_ir, tap_st, RTI);
    end
  endtask

  task automatic test_len_rules();
    int n, start;
    logic [31:0] v_tms, v_tdi;
    logic [DATA_W-1:0] rsp;
    bit got, pok;
    // len 0 scans one bit
    do_cmd(2'b10, 5'd0, 16'h0001, n, v_tms, v_tdi, rsp, got, pok);
    n_vec++;
    if (!got || !pok || n != 6 || v_tms[5:0] !== 6'b011001 || v_tdi[3] !== 1'b1) begin
      n_err++;
      $display("FAIL dr0_shape: got=%0d ok=%0d count=%0d tms=%b tdi3=%b required 1 1 6 011001 1",
               got, pok, n, v_tms[5:0], v_tdi[3]);
    end
    n_vec++;
    if (rsp !== 16'h0001 || tap_dr !== 16'hD2E1) begin
      n_err++;
      $display("FAIL dr0_data: rsp=%h dr=%h required 0001 d2e1", rsp, tap_dr);
    end
    // len 20 clamps to 16
    do_cmd(2'b10, 5'd20, 16'h0F0F, n, v_tms, v_tdi, rsp, got, pok);
    n_vec++;
    if (!got || !pok || n != 21 || v_tms[20:0] !== 21'h0C0001) begin
      n_err++;
      $display("FAIL dr20_shape: got=%0d ok=%0d count=%0d tms=%h required 1 1 21 0c0001",
               got, pok, n, v_tms[20:0]);
    end
    n_vec++;
    if (rsp !== 16'hD2E1 || tap_dr !== 16'h0F0F) begin
      n_err++;
      $display("FAIL dr20_data: rsp=%h dr=%h required d2e1 0f0f", rsp, tap_dr);
    end
    // idle clocks
    do_cmd(2'b11, 5'd3, 16'hFFFF, n, v_tms, v_tdi, rsp, got, pok);
    n_vec++;
    if (!got || !pok || n != 3 || v_tms[2:0] !== 3'b000 || rsp !== 16'h0 || tap_st != RTI) begin
      n_err++;
      $display("FAIL idle3: got=%0d ok=%0d count=%0d tms=%b rsp=%h st=%0d required 1 1 3 000 0000 %0d",
               got, pok, n, v_tms[2:0], rsp, tap_st, RTI);
    end
    // TAP reset command
    do_cmd(2'b00, 5'd0, 16'h0000, n, v_tms, v_tdi, rsp, got, pok);
    n_vec++;
    if (!got || !pok || n != 6 || v_tms[5:0] !== 6'b011111 || tap_st != RTI) begin
      n_err++;
      $display("FAIL trst: got=%0d ok=%0d count=%0d tms=%b st=%0d required 1 1 6 011111 %0d",
               got, pok, n, v_tms[5:0], tap_st, RTI);
    end
    // idle len 0: strobe one cycle after acceptance, no TCK
    start = tck_tms.size();
    send_cmd(2'b11, 5'd0, 16'h0000);
    n_vec++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle0_accept_cycle: rspv=%b ready=%b required 0 0", rsp_valid, cmd_ready);
    end
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b1 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle0_rsp: rspv=%b ready=%b required 1 1", rsp_valid, cmd_ready);
    end
    @(negedge clk);
    n_vec++;
    if (tck_tms.size() != start) begin
      n_err++;
      $display("FAIL idle0_tck: got %0d pulses required 0", tck_tms.size() - start);
    end
  endtask

  task automatic test_back_to_back();
    int start, a0, seen, guard, n;
    bit ready_in_rsp;
    logic [31:0] v_tms, v_tdi;
    start = tck_tms.size();
    a0 = acc_cnt;
    seen = 0;
    guard = 0;
    ready_in_rsp = 1'b1;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    cmd_op    = 2'b11;
    cmd_len   = 5'd2;
    cmd_data  = '0;
    cmd_valid = 1'b1;
    guard = 0;
    while (seen < 3 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (rsp_valid === 1'b1) begin
        seen++;
        if (cmd_ready !== 1'b1) ready_in_rsp = 1'b0;
        if (seen == 3) cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    grab(start, n, v_tms, v_tdi);
    n_vec++;
    if (seen != 3) begin n_err++; $display("FAIL b2b_rsp_count: got %0d required 3", seen); end
    n_vec++;
    if (acc_cnt - a0 != 3) begin
      n_err++;
      $display("FAIL b2b_accepts: got %0d required 3", acc_cnt - a0);
    end
    n_vec++;
    if (n != 6 || !ready_in_rsp) begin
      n_err++;
      $display("FAIL b2b_tck_ready: count=%0d ready_in_rsp=%0d required 6 1", n, ready_in_rsp);
    end
  endtask

  task automatic test_reset_mid_scan();
    int start, p0, guard, n;
    logic [31:0] v_tms, v_tdi;
    start = tck_tms.size();
    p0 = rsp_pulses;
    send_cmd(2'b10, 5'd16, 16'hFFFF);
    guard = 0;
    while (tck_tms.size() - start < 11 && guard < 1000) begin @(negedge clk); guard++; end
    n_vec++;
    if (guard >= 1000) begin
      n_err++;
      $display("FAIL midrst_reach_bit7: got %0d TCKs required 11", tck_tms.size() - start);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({tck, tms, tdi, cmd_ready, rsp_valid, busy} !== 6'b010001 || rsp_data !== 16'h0) begin
      n_err++;
      $display("FAIL midrst_pins: tck,tms,tdi,rdy,rspv,busy=%b rsp=%h required 010001 0000",
               {tck, tms, tdi, cmd_ready, rsp_valid, busy}, rsp_data);
    end
    repeat (2) @(negedge clk);
    start = tck_tms.size();
    rst = 1'b0;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 400) begin @(negedge clk); guard++; end
    grab(start, n, v_tms, v_tdi);
    n_vec++;
    if (n != 6 || v_tms[5:0] !== 6'b011111 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_reinit: count=%0d tms=%b busy=%b required 6 011111 0", n, v_tms[5:0], busy);
    end
    n_vec++;
    if (rsp_pulses != p0 || tap_st != RTI) begin
      n_err++;
      $display("FAIL midrst_abort: rsp pulses=%0d tap=%0d required 0 %0d", rsp_pulses - p0, tap_st, RTI);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dr_scan();
    test_ir_scan();
    test_len_rules();
    test_back_to_back();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
